// File: rtl/noc_pio_bridge.sv
// noc_pio_bridge: PIO <-> NoC packet bridge with TX/RX FIFOs; optional drop counter (NOC_PIO_DROP_CNT_EN).
// Latency: send/pop strobe or NoC handshake in cycle N is visible on outputs from N+1.
// Backpressure: noc_tx_valid/ready drains TX; noc_rx_ready drops when RX is full; sends into a full TX are lost and flag tx_ovf.

// noc_pio_fifo: generic pointer-based FIFO, storage not reset.
// Latency: push in cycle N is at the head from N+1 when the FIFO was empty.
// Backpressure: push ignored while full, pop ignored while empty; both judged on registered pointers.
module noc_pio_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok  = push_vld && !full;
  assign pop_ok   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle both advance.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents survive reset, only the pointers are cleared.
  always_ff @(posedge core_clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module noc_pio_bridge #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                TX_DEPTH = 4,
  parameter int                RX_DEPTH = 4,
  parameter logic [ADDR_W-1:0] NODE_ID  = '0
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [ADDR_W-1:0]          pio_dest,
  input  logic [DATA_W-1:0]          pio_wdata,
  input  logic [2:0]                 pio_ctrl,
  output logic [ADDR_W-1:0]          pio_rsrc,
  output logic [DATA_W-1:0]          pio_rdata,
  output logic [15:0]                pio_status,
  output logic                       noc_tx_valid,
  input  logic                       noc_tx_ready,
  output logic [2*ADDR_W+DATA_W-1:0] noc_tx_data,
  input  logic                       noc_rx_valid,
  output logic                       noc_rx_ready,
  input  logic [2*ADDR_W+DATA_W-1:0] noc_rx_data
);
  localparam int PKT_W = 2*ADDR_W + DATA_W;
  localparam int RXE_W = ADDR_W + DATA_W;

  logic [1:0]        ctrl_q;
  logic              send_vld;
  logic              pop_vld;
  logic              tx_full;
  logic              tx_empty;
  logic [PKT_W-1:0]  tx_head_dat;
  logic              tx_pop_vld;
  logic              tx_ovf;
  logic              run_q;
  logic              rx_full;
  logic              rx_empty;
  logic [RXE_W-1:0]  rx_head_dat;
  logic              rx_xfer;
  logic              rx_hit;
  logic              rx_push_vld;
  logic [ADDR_W-1:0] rx_dest;
  logic [7:0]        drop_cnt;

  // Toggle strobes: a change on pio_ctrl[1:0] relative to last cycle is one event.
  assign send_vld = pio_ctrl[0] ^ ctrl_q[0];
  assign pop_vld  = pio_ctrl[1] ^ ctrl_q[1];

  // Remember last ctrl level; run_q keeps noc_rx_ready low while reset is asserted.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctrl_q <= '0;
      run_q  <= 1'b0;
    end else begin
      ctrl_q <= pio_ctrl[1:0];
      run_q  <= 1'b1;
    end
  end

  noc_pio_fifo #(.W(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .core_clk (clk_clk),
    .arst_n   (reset_reset_n),
    .push_vld (send_vld),
    .push_dat ({pio_dest, NODE_ID, pio_wdata}),
    .pop_vld  (tx_pop_vld),
    .full     (tx_full),
    .empty    (tx_empty),
    .head_dat (tx_head_dat)
  );

  // Head is gated to zero when empty so stale storage never leaks out.
  assign noc_tx_valid = !tx_empty;
  assign noc_tx_data  = tx_empty ? '0 : tx_head_dat;
  assign tx_pop_vld   = noc_tx_valid && noc_tx_ready;

  // Sticky overflow: a lost send sets it and beats a concurrent clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_ovf <= 1'b0;
    end else if (send_vld && tx_full) begin
      tx_ovf <= 1'b1;
    end else if (pio_ctrl[2]) begin
      tx_ovf <= 1'b0;
    end
  end

  // Ready depends only on registered state, never on noc_tx_ready or noc_rx_valid.
  assign noc_rx_ready = run_q && !rx_full;
  assign rx_xfer      = noc_rx_valid && noc_rx_ready;
  assign rx_dest      = noc_rx_data[PKT_W-1 -: ADDR_W];
  assign rx_hit       = (rx_dest == NODE_ID);
  assign rx_push_vld  = rx_xfer && rx_hit;

  noc_pio_fifo #(.W(RXE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .core_clk (clk_clk),
    .arst_n   (reset_reset_n),
    .push_vld (rx_push_vld),
    .push_dat (noc_rx_data[RXE_W-1:0]),
    .pop_vld  (pop_vld),
    .full     (rx_full),
    .empty    (rx_empty),
    .head_dat (rx_head_dat)
  );

  assign pio_rsrc  = rx_empty ? '0 : rx_head_dat[RXE_W-1 -: ADDR_W];
  assign pio_rdata = rx_empty ? '0 : rx_head_dat[DATA_W-1:0];

`ifdef NOC_PIO_DROP_CNT_EN
  logic rx_drop_vld;
  assign rx_drop_vld = rx_xfer && !rx_hit;

  // Saturating count of misaddressed packets; only reset clears it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      drop_cnt <= '0;
    end else if (rx_drop_vld && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

  assign pio_status = {drop_cnt, 4'b0000, tx_ovf, !rx_empty, tx_empty, tx_full};
endmodule

// File: tb/tb_noc_pio_bridge.sv
// Bench for noc_pio_bridge: directed scenarios plus random traffic checked each cycle
// against a queue-based model of the TX/RX packet buffers, overflow flag and drop counter.
module tb_noc_pio_bridge;
  localparam int          AW  = 8;
  localparam int          DW  = 32;
  localparam int          PW  = 2*AW + DW;
  localparam int          TXD = 4;
  localparam int          RXD = 4;
  localparam logic [7:0]  NID = 8'h3C;

  logic          clk_clk;
  logic          reset_reset_n;
  logic [AW-1:0] pio_dest;
  logic [DW-1:0] pio_wdata;
  logic [2:0]    pio_ctrl;
  logic [AW-1:0] pio_rsrc;
  logic [DW-1:0] pio_rdata;
  logic [15:0]   pio_status;
  logic          noc_tx_valid;
  logic          noc_tx_ready;
  logic [PW-1:0] noc_tx_data;
  logic          noc_rx_valid;
  logic          noc_rx_ready;
  logic [PW-1:0] noc_rx_data;

  noc_pio_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .NODE_ID(NID)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .pio_dest      (pio_dest),
    .pio_wdata     (pio_wdata),
    .pio_ctrl      (pio_ctrl),
    .pio_rsrc      (pio_rsrc),
    .pio_rdata     (pio_rdata),
    .pio_status    (pio_status),
    .noc_tx_valid  (noc_tx_valid),
    .noc_tx_ready  (noc_tx_ready),
    .noc_tx_data   (noc_tx_data),
    .noc_rx_valid  (noc_rx_valid),
    .noc_rx_ready  (noc_rx_ready),
    .noc_rx_data   (noc_rx_data)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: packet queues plus flag/counter.
  logic [PW-1:0]    txq[$];
  logic [AW+DW-1:0] rxq[$];
  bit               m_ovf;
  int               m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [PW-1:0]    th;
    logic [AW+DW-1:0] rh;
    th = (txq.size() != 0) ? txq[0] : '0;
    rh = (rxq.size() != 0) ? rxq[0] : '0;
    chk("tx_full",      64'(pio_status[0]),    64'(txq.size() == TXD));
    chk("tx_empty",     64'(pio_status[1]),    64'(txq.size() == 0));
    chk("rx_valid",     64'(pio_status[2]),    64'(rxq.size() != 0));
    chk("tx_ovf",       64'(pio_status[3]),    64'(m_ovf));
    chk("status_rsvd",  64'(pio_status[7:4]),  64'(0));
    chk("drop_cnt",     64'(pio_status[15:8]), 64'(m_drop));
    chk("noc_tx_valid", 64'(noc_tx_valid),     64'(txq.size() != 0));
    chk("noc_tx_data",  64'(noc_tx_data),      64'(th));
    chk("noc_rx_ready", 64'(noc_rx_ready),     64'(rxq.size() < RXD));
    chk("pio_rsrc",     64'(pio_rsrc),         64'(rh[AW+DW-1:DW]));
    chk("pio_rdata",    64'(pio_rdata),        64'(rh[DW-1:0]));
  endtask

  // One clock: drive inputs, advance model from pre-edge state, check after the edge.
  task automatic step(input bit send, input bit pop, input bit clr, input bit txr,
                      input bit rxv, input logic [7:0] rdest, input logic [7:0] rsrc,
                      input logic [31:0] rpay);
    int tsz;
    int rsz;
    bit tx_hs;
    bit rx_xfer;
    logic [PW-1:0] pkt;
    if (send) pio_ctrl[0] = ~pio_ctrl[0];
    if (pop)  pio_ctrl[1] = ~pio_ctrl[1];
    pio_ctrl[2]  = clr;
    noc_tx_ready = txr;
    noc_rx_valid = rxv;
    noc_rx_data  = {rdest, rsrc, rpay};
    tsz     = txq.size();
    rsz     = rxq.size();
    tx_hs   = (tsz > 0) && txr;
    rx_xfer = rxv && (rsz < RXD);
    pkt     = {pio_dest, NID, pio_wdata};
    @(posedge clk_clk);
    #1;
    if (tx_hs) void'(txq.pop_front());
    if (send && tsz < TXD) txq.push_back(pkt);
    if (send && tsz == TXD) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop && rsz > 0) void'(rxq.pop_front());
    if (rx_xfer) begin
      if (rdest == NID) rxq.push_back({rsrc, rpay});
`ifdef NOC_PIO_DROP_CNT_EN
      else if (m_drop < 255) m_drop++;
`endif
    end
    check_outputs();
  endtask

  task automatic idle(input bit txr);
    step(0, 0, 0, txr, 0, 8'h00, 8'h00, 32'h0);
  endtask

  // Assert reset with inputs as they are, check async output values, then release cleanly.
  task automatic do_reset();
    reset_reset_n = 1'b0;
    #1;
    chk("rst_noc_tx_valid", 64'(noc_tx_valid), 64'(0));
    chk("rst_noc_tx_data",  64'(noc_tx_data),  64'(0));
    chk("rst_noc_rx_ready", 64'(noc_rx_ready), 64'(0));
    chk("rst_pio_rsrc",     64'(pio_rsrc),     64'(0));
    chk("rst_pio_rdata",    64'(pio_rdata),    64'(0));
    chk("rst_pio_status",   64'(pio_status),   64'h0002);
    pio_ctrl = 3'b000; noc_tx_ready = 1'b0; noc_rx_valid = 1'b0; noc_rx_data = '0;
    txq.delete(); rxq.delete(); m_ovf = 1'b0; m_drop = 0;
    @(posedge clk_clk);
    @(posedge clk_clk);
    #2 reset_reset_n = 1'b1;
    idle(0);
    idle(0);
  endtask

  initial begin
    reset_reset_n = 1'b1;
    pio_dest = '0; pio_wdata = '0; pio_ctrl = 3'b000;
    noc_tx_ready = 1'b0; noc_rx_valid = 1'b0; noc_rx_data = '0;
    m_ovf = 1'b0; m_drop = 0;
    #3;
    do_reset();

    // Three back-to-back sends drained at full rate.
    pio_dest = 8'h05;
    for (int i = 0; i < 3; i++) begin
      pio_wdata = 32'hA1 + i;
      step(1, 0, 0, 1, 0, 8'h00, 8'h00, 32'h0);
    end
    for (int i = 0; i < 3; i++) idle(1);

    // Five sends with the NoC stalled: fourth fills, fifth overflows.
    for (int i = 0; i < 5; i++) begin
      pio_dest = 8'($urandom); pio_wdata = $urandom;
      step(1, 0, 0, 0, 0, 8'h00, 8'h00, 32'h0);
    end
    chk("ovf_after_fifth", 64'(pio_status[3]), 64'(1));
    for (int i = 0; i < 6; i++) idle(1);
    step(0, 0, 1, 0, 0, 8'h00, 8'h00, 32'h0);

    // RX fill with valid held high, then pops in order.
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 1, NID, 8'($urandom), $urandom);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0);

    // Misaddressed packets, then enough to saturate the counter.
    step(0, 0, 0, 0, 1, NID ^ 8'h01, 8'h11, 32'hDEAD0001);
    step(0, 0, 0, 0, 1, NID ^ 8'h80, 8'h12, 32'hDEAD0002);
    idle(0);
    for (int i = 0; i < 300; i++)
      step(0, 0, 0, 0, 1, NID ^ 8'($urandom_range(1, 255)), 8'($urandom), $urandom);
    idle(0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : NID;
      pio_dest = 8'($urandom); pio_wdata = $urandom;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), d, 8'($urandom), $urandom);
    end

    // Reset mid-handshake with two entries in each FIFO.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pio_dest = 8'($urandom); pio_wdata = $urandom;
      step(1, 0, 0, 0, 1, NID, 8'($urandom), $urandom);
    end
    noc_tx_ready = 1'b1;
    noc_rx_valid = 1'b1;
    noc_rx_data  = {NID, 8'h77, 32'h12345678};
    #3;
    do_reset();
    step(0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/noc_pio_bridge.md
# noc_pio_bridge

Parametrised network interface between a processor's PIO ports and the NoC, replacing fixed-width addr/data PIO wiring with buffered, flow-controlled packet transfer. The processor queues outgoing packets into a TX FIFO using toggle strobes. It reads incoming packets addressed to this node from an RX FIFO. The NoC side uses valid/ready handshakes. One instance sits per processing node, between its PIO block and the NoC router port.

## Interface
- ADDR_W, 8: node address width.
- DATA_W, 32: payload width.
- TX_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- RX_DEPTH, 4: RX FIFO entries; power of two, ≥2.
- NODE_ID, 0: this node's address, ADDR_W bits.

Ports:
- clk_clk  in  1  sole clock, rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- pio_dest  in  ADDR_W  destination of the packet to send.
- pio_wdata  in  DATA_W  payload of the packet to send.
- pio_ctrl  in  3  [0] send toggle, [1] pop toggle, [2] clear tx_ovf (level).
- pio_rsrc  out  ADDR_W  source field of RX head; 0 when RX empty.
- pio_rdata  out  DATA_W  payload of RX head; 0 when RX empty.
- pio_status  out  16  [0] tx_full, [1] tx_empty, [2] rx_valid, [3] tx_ovf (sticky), [7:4] 0, [15:8] drop_cnt.
- noc_tx_valid / noc_tx_ready  out / in  1  TX handshake.
- noc_tx_data  out  2*ADDR_W+DATA_W  packet as {dest, src=NODE_ID, payload}.
- noc_rx_valid / noc_rx_ready  in / out  1  RX handshake.
- noc_rx_data  in  2*ADDR_W+DATA_W  packet in the same format.

## Operation
- Strobe detect: ctrl_q holds registered pio_ctrl[1:0]; reset value 0. send = pio_ctrl[0]^ctrl_q[0]; pop = pio_ctrl[1]^ctrl_q[1].
- Send, TX not full: push {pio_dest, NODE_ID, pio_wdata} sampled in the strobe cycle.
- Send, TX full: packet discarded; tx_ovf set.
- tx_ovf: cleared while pio_ctrl[2]=1. Set wins over clear in the same cycle.
- TX drain:
  - noc_tx_valid = !tx_empty; noc_tx_data = TX head.
  - Pop head on noc_tx_valid & noc_tx_ready.
  - Data must stay stable while valid and not ready.
- RX accept:
  - noc_rx_ready = !rx_full, a function of registered state only.
  - A transfer is noc_rx_valid & noc_rx_ready.
  - dest==NODE_ID: push {src, payload}.
  - Otherwise: discard and increment drop_cnt (see Configuration).
- Pop strobe with RX not empty: advance head. Pop with RX empty: ignored, no state change.
- Full/empty flags come from read/write pointers with one extra wrap bit; pointers wrap modulo depth.
- Same-cycle push and pop on a non-full, non-empty FIFO: both take effect, count unchanged.
- Push while full is never accepted, even with a simultaneous pop, because full is evaluated from registered state.
- Reset, including mid-transfer:
  - Pointers, ctrl_q, tx_ovf and drop_cnt clear.
  - All outputs 0 except pio_status[1]=1 (tx_empty).
  - FIFO contents are not cleared; in-flight packets are lost.

## Timing
- Send strobe in cycle N: noc_tx_valid high from N+1 if TX was empty.
- RX handshake in cycle N: rx_valid, pio_rsrc and pio_rdata valid from N+1.
- Pop strobe in cycle N: next head (or zeros) visible from N+1.
- Status flags are registered FIFO state, updated the cycle after the event.
- TX throughput: one packet per cycle. RX throughput: one packet per cycle while not full.
- No combinational path from noc_tx_ready to noc_rx_ready or to any PIO output.

## Configuration
- NOC_PIO_DROP_CNT_EN defined:
  - drop_cnt is an 8-bit saturating counter of discarded misaddressed packets; holds at 255.
  - Cleared by reset only.
- NOC_PIO_DROP_CNT_EN undefined:
  - Misaddressed packets are still discarded.
  - pio_status[15:8] tied to 0; counter logic absent.

## Test plan
- Reset, then three send toggles with dest=8'h05, data=32'hA1/A2/A3, noc_tx_ready=1: noc_tx_data in order {05, NODE_ID, A1..A3}, one per cycle starting N+1; tx_empty returns to 1.
- noc_tx_ready=0, five send toggles, TX_DEPTH=4: tx_full=1 after the fourth; the fifth sets tx_ovf. Raise ready: exactly four packets leave. pio_ctrl[2]=1 clears tx_ovf.
- Hold noc_rx_valid=1 with dest=NODE_ID and no pops: four packets accepted, then noc_rx_ready=0. Pop toggles return the payloads in order; ready reasserts the cycle after the first pop.
- Inject two packets with dest≠NODE_ID: rx_valid stays 0; drop_cnt=2 with the macro, 0 without. 300 drops with the macro: drop_cnt saturates at 255.
- With RX and TX each holding 2 entries, assert reset_reset_n=0 mid-handshake: all outputs zero except tx_empty=1, asynchronously. After release, a pop toggle on the empty RX is ignored.
